// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one 32-bit memory port between instruction fetch and the load/store
// unit. Data normally wins a contested cycle. A saturating starvation counter
// forces a fetch grant after STARVE_LIMIT consecutive contested data wins.
// A jump/flush cancels pending and outstanding fetches so that stale
// instruction words never reach the fetch unit.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned RST_STATE    = 0
) (
  input  logic        clk,
  input  logic        rst,
  // fetch side
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  // load/store side
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  // memory side
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  // IDLE takes the configured encoding; the busy states follow it so that
  // all three encodings stay distinct for any choice of RST_STATE.
  localparam logic [1:0] IDLE_ENC   = RST_STATE[1:0];
  localparam logic [7:0] STARVE_MAX = STARVE_LIMIT[7:0];

  typedef enum logic [1:0] {
    IDLE    = IDLE_ENC,
    IF_BUSY = IDLE_ENC + 2'd1,
    D_BUSY  = IDLE_ENC + 2'd2
  } state_t;

  state_t      state_r;
  logic [7:0]  starve_cnt_r;
  logic        drop_r;

  logic        mem_req_r;
  logic        mem_we_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic [3:0]  mem_be_r;
  logic        if_rvalid_r;
  logic [31:0] if_rdata_r;
  logic        d_rvalid_r;
  logic [31:0] d_rdata_r;

  logic        fetch_ok_s;
  logic        contested_s;
  logic        starved_s;
  logic        if_gnt_s;
  logic        d_gnt_s;

  // Grant decision: only while idle, data first unless fetch has starved.
  always_comb begin
    fetch_ok_s  = if_req & ~if_flush;
    contested_s = fetch_ok_s & d_req;
    starved_s   = (starve_cnt_r == STARVE_MAX);
    if_gnt_s    = 1'b0;
    d_gnt_s     = 1'b0;
    if (state_r == IDLE) begin
      if (contested_s) begin
        if (starved_s) begin
          if_gnt_s = 1'b1;
        end else begin
          d_gnt_s = 1'b1;
        end
      end else if (fetch_ok_s) begin
        if_gnt_s = 1'b1;
      end else if (d_req) begin
        d_gnt_s = 1'b1;
      end else begin
        if_gnt_s = 1'b0;
        d_gnt_s  = 1'b0;
      end
    end else begin
      if_gnt_s = 1'b0;
      d_gnt_s  = 1'b0;
    end
  end

  // Starvation counter: counts contested data wins, cleared by any fetch grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_r <= 8'd0;
    end else if (if_gnt_s) begin
      starve_cnt_r <= 8'd0;
    end else if (d_gnt_s && contested_s && (starve_cnt_r != STARVE_MAX)) begin
      starve_cnt_r <= starve_cnt_r + 8'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Port FSM: latches the winner's request, holds it until ack, returns data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      drop_r      <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0;
      mem_wdata_r <= 32'h0;
      mem_be_r    <= 4'h0;
      if_rvalid_r <= 1'b0;
      if_rdata_r  <= 32'h0;
      d_rvalid_r  <= 1'b0;
      d_rdata_r   <= 32'h0;
    end else begin
      // completion strobes are single-cycle pulses
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (if_gnt_s) begin
            state_r     <= IF_BUSY;
            drop_r      <= 1'b0;
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= if_addr;
            mem_wdata_r <= 32'h0;
            mem_be_r    <= 4'hF;
          end else if (d_gnt_s) begin
            state_r     <= D_BUSY;
            mem_req_r   <= 1'b1;
            mem_we_r    <= d_we;
            mem_addr_r  <= d_addr;
            mem_wdata_r <= d_wdata;
            mem_be_r    <= d_be;
          end else begin
            // a stray mem_ack while idle is ignored
            state_r   <= IDLE;
            mem_req_r <= 1'b0;
          end
        end
        IF_BUSY: begin
          if (mem_ack) begin
            state_r     <= IDLE;
            mem_req_r   <= 1'b0;
            if_rdata_r  <= mem_rdata;
            // a flush now or earlier in this access discards the word
            if_rvalid_r <= ~(drop_r | if_flush);
            drop_r      <= 1'b0;
          end else if (if_flush) begin
            drop_r <= 1'b1;
          end else begin
            drop_r <= drop_r;
          end
        end
        D_BUSY: begin
          // flushes do not touch a data access
          if (mem_ack) begin
            state_r    <= IDLE;
            mem_req_r  <= 1'b0;
            d_rdata_r  <= mem_rdata;
            d_rvalid_r <= 1'b1;
          end else begin
            state_r <= D_BUSY;
          end
        end
        default: begin
          // unreachable encoding: recover to idle with the port released
          state_r   <= IDLE;
          drop_r    <= 1'b0;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign if_gnt    = if_gnt_s;
  assign d_gnt     = d_gnt_s;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_be    = mem_be_r;
  assign if_rvalid = if_rvalid_r;
  assign if_rdata  = if_rdata_r;
  assign d_rvalid  = d_rvalid_r;
  assign d_rdata   = d_rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// all compared against a transaction-level reference model of the port.
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, if_flush = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = 32'h0, d_wdata = 32'h0;
  logic [3:0]  d_be = 4'h0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .RST_STATE(0)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int total = 0;
  int bad = 0;

  // Reference model: who owns the port, the pending access, last results.
  int          m_owner;   // 0 = free, 1 = fetch, 2 = data
  int          m_cnt;
  bit          m_drop;
  bit          m_req, m_we, m_ifv, m_dv;
  logic [31:0] m_addr, m_wdata, m_ifr, m_dr;
  logic [3:0]  m_be;
  logic        obs_ig, obs_dg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_cnt = 0; m_drop = 1'b0;
    m_req = 1'b0; m_we = 1'b0; m_ifv = 1'b0; m_dv = 1'b0;
    m_addr = 32'h0; m_wdata = 32'h0; m_ifr = 32'h0; m_dr = 32'h0; m_be = 4'h0;
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_flush = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
  endtask

  // One clock: check outputs mid-cycle against the model, then apply the
  // arbitration rules to the model for the coming edge.
  task automatic step();
    bit fok, eig, edg;
    @(negedge clk);
    fok = if_req && !if_flush;
    eig = (m_owner == 0) && fok && (!d_req || m_cnt == LIMIT);
    edg = (m_owner == 0) && d_req && !eig;
    obs_ig = if_gnt;
    obs_dg = d_gnt;
    chk("if_gnt", if_gnt, eig);
    chk("d_gnt", d_gnt, edg);
    chk("mem_req", mem_req, m_req);
    chk("starve_cnt", dut.starve_cnt_r, m_cnt);
    if (m_req) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_be", mem_be, m_be);
      chk("mem_we", mem_we, m_we);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("if_rvalid", if_rvalid, m_ifv);
    chk("d_rvalid", d_rvalid, m_dv);
    if (m_ifv) chk("if_rdata", if_rdata, m_ifr);
    if (m_dv) chk("d_rdata", d_rdata, m_dr);
    m_ifv = 1'b0;
    m_dv  = 1'b0;
    if (m_owner == 0) begin
      if (eig) begin
        m_owner = 1; m_req = 1'b1; m_we = 1'b0; m_be = 4'hF; m_addr = if_addr;
        m_cnt = 0; m_drop = 1'b0;
      end else if (edg) begin
        m_owner = 2; m_req = 1'b1; m_we = d_we; m_be = d_be; m_addr = d_addr;
        m_wdata = d_wdata;
        if (fok) m_cnt = (m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1;
      end
    end else if (mem_ack) begin
      m_req = 1'b0;
      if (m_owner == 1) begin
        m_ifv = !(m_drop || if_flush);
        m_ifr = mem_rdata;
      end else begin
        m_dv = 1'b1;
        m_dr = mem_rdata;
      end
      m_owner = 0;
      m_drop = 1'b0;
    end else if (m_owner == 1 && if_flush) begin
      m_drop = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_grant, fetch_at, nv;
    logic [31:0] wd;
    model_reset();

    // 1: reset state, then reset in the middle of a data access
    #12;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", mem_be, 4'h0);
    chk("rst_if_rvalid", if_rvalid, 1'b0);
    chk("rst_d_rvalid", d_rvalid, 1'b0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h1111_2222; d_be = 4'hF;
    step();
    d_req = 1'b0;
    chk("t1_busy_req", mem_req, 1'b1);
    step();
    rst = 1'b1;
    #1;
    chk("t1_async_mem_req", mem_req, 1'b0);
    chk("t1_async_d_rvalid", d_rvalid, 1'b0);
    chk("t1_async_if_rvalid", if_rvalid, 1'b0);
    chk("t1_async_mem_addr", mem_addr, 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ack = 1'b1;  // stray ack while idle must be ignored
    step();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // 2: fetch only
    if_req = 1'b1; if_addr = 32'h0000_0100;
    step();
    chk("t2_if_gnt", obs_ig, 1'b1);
    if_req = 1'b0;
    chk("t2_mem_addr", mem_addr, 32'h100);
    chk("t2_mem_be", mem_be, 4'hF);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
    step();
    mem_ack = 1'b0;
    chk("t2_if_rvalid", if_rvalid, 1'b1);
    chk("t2_if_rdata", if_rdata, 32'h13);
    step();

    // 3: contested traffic, fetch forced in on the fifth arbitration
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_be = 4'h3;
    n_grant = 0; fetch_at = 0;
    for (int i = 0; i < 40 && fetch_at == 0; i++) begin
      mem_ack = mem_req; mem_rdata = $urandom;
      step();
      if (obs_ig === 1'b1 || obs_dg === 1'b1) n_grant++;
      if (obs_ig === 1'b1) fetch_at = n_grant;
    end
    chk("t3_fetch_grant_pos", fetch_at, 5);
    chk("t3_cnt_cleared", dut.starve_cnt_r, 8'd0);
    if_req = 1'b0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    d_req = 1'b0;
    mem_ack = 1'b1;
    step();
    clear_inputs();
    step();

    // 4: flush while a fetch is outstanding
    if_req = 1'b1; if_addr = 32'h40;
    step();
    chk("t4_gnt40", obs_ig, 1'b1);
    if_req = 1'b0; if_flush = 1'b1;
    step();
    if_flush = 1'b0;
    step();
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_0040;
    step();
    mem_ack = 1'b0;
    chk("t4_no_rvalid", if_rvalid, 1'b0);
    if_req = 1'b1; if_addr = 32'h80;
    step();
    chk("t4_gnt80", obs_ig, 1'b1);
    if_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_0080;
    step();
    mem_ack = 1'b0;
    chk("t4_rvalid80", if_rvalid, 1'b1);
    chk("t4_rdata80", if_rdata, 32'hCAFE_0080);
    step();

    // 5: flush in idle lets data through without counting as contested
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_be = 4'hF;
    step();
    clear_inputs();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("t5_cnt_one", dut.starve_cnt_r, 8'd1);
    if_req = 1'b1; if_flush = 1'b1; d_req = 1'b1;
    step();
    chk("t5_d_gnt", obs_dg, 1'b1);
    chk("t5_if_gnt", obs_ig, 1'b0);
    chk("t5_cnt_held", dut.starve_cnt_r, 8'd1);
    clear_inputs();
    mem_ack = 1'b1;
    step();
    clear_inputs();
    step();

    // 6: slow write, request held stable, single completion pulse
    wd = $urandom;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = wd; d_be = 4'h5;
    step();
    d_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk("t6_req_held", mem_req, 1'b1);
      chk("t6_addr", mem_addr, 32'h44);
      chk("t6_wdata", mem_wdata, wd);
      chk("t6_be", mem_be, 4'h5);
      mem_ack = (k == 3);
      step();
    end
    mem_ack = 1'b0;
    nv = 0;
    for (int k = 0; k < 4; k++) begin
      if (d_rvalid === 1'b1) nv++;
      step();
    end
    chk("t6_one_rvalid", nv, 1);

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      if_req    = ($urandom_range(99) < 60);
      if_addr   = {$urandom_range(32'h7FFF_FFFF), 1'b0};
      if_flush  = ($urandom_range(99) < 12);
      d_req     = ($urandom_range(99) < 55);
      d_we      = $urandom_range(1);
      d_addr    = $urandom;
      d_wdata   = $urandom;
      d_be      = 4'($urandom_range(15));
      mem_ack   = ($urandom_range(99) < 40);
      mem_rdata = $urandom;
      step();
    end
    clear_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 32-bit instruction/data memory port between the fetch unit and the load/store unit of the Rv32 core.
- Data accesses take priority by default. A starvation counter guarantees forward progress for fetch.
- A jump/flush input cancels an outstanding fetch so that stale instruction words never reach the fetch unit.
- Sits between the fetch/LSU pipeline stages and the memory interface.

Parameters:
- STARVE_LIMIT, 4: number of consecutive contested arbitrations that data may win before fetch is forced to win. Legal range 1..255.
- RST_STATE, 0: encoding of IDLE.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- if_req  in  1  fetch request. Held with if_addr until if_gnt.
- if_addr  in  32  fetch address (halfword aligned).
- if_flush  in  1  jump taken. Cancels any pending or outstanding fetch.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  32  fetched word.
- d_req  in  1  data request. Held with d_* until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  32  data address.
- d_wdata  in  32  write data.
- d_be  in  4  byte enables.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle completion pulse (reads and writes).
- d_rdata  out  32  read data (captured on writes too; content don't-care).
- mem_req  out  1  memory request. Held until mem_ack.
- mem_we  out  1  write strobe.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_be  out  4  byte enables (4'hF for fetch).
- mem_ack  in  1  one-cycle pulse: access complete, mem_rdata valid.
- mem_rdata  in  32  memory read data.

Behaviour:
- States:
  - IDLE: no memory access in progress.
  - IF_BUSY: fetch access in progress.
  - D_BUSY: data access in progress.
- Reset (async, immediate):
  - state is IDLE; starve_cnt and drop flag are 0.
  - mem_req, mem_we, if_rvalid and d_rvalid are 0.
  - mem_addr, mem_wdata, if_rdata and d_rdata are 32'h0; mem_be is 4'h0.
  - A reset in the middle of a transaction abandons it; no rvalid is produced afterwards.
- Grant logic (combinational, IDLE only):
  - fetch_ok = if_req & ~if_flush.
  - If d_req and fetch_ok are both set: fetch wins when starve_cnt == STARVE_LIMIT; otherwise data wins.
  - If only one requester is active, that requester wins.
  - if_gnt and d_gnt are never both 1.
  - Both grants are 0 outside IDLE.
- Grant edge (cycle T):
  - The winner's address, wdata, be and we are registered.
  - The state moves to the matching BUSY state.
  - From T+1, mem_req = 1 with stable outputs until mem_ack.
  - For fetch: mem_we = 0 and mem_be = 4'hF.
- Starvation counter:
  - Increments on each contested cycle that data wins (saturates at STARVE_LIMIT).
  - Clears whenever fetch is granted.
  - Holds its value otherwise.
- Completion (mem_ack in cycle A):
  - mem_req drops at A+1.
  - The state returns to IDLE at A+1, so a new grant is possible in cycle A+1.
  - The matching rvalid pulses in A+1, with rdata registered from mem_rdata.
  - mem_ack in IDLE is ignored.
- Minimum access: grant at T, ack at T+1, rvalid at T+2. Back-to-back throughput is one access per 2 cycles.
- Flush:
  - if_flush in IDLE suppresses if_gnt for that cycle. A pending data request may be granted.
  - if_flush during IF_BUSY sets drop. The access still runs to mem_ack, but if_rvalid is suppressed and drop clears at completion.
  - if_flush during D_BUSY has no effect on the data access.
  - if_flush in the same cycle as mem_ack of a fetch suppresses that if_rvalid.
- Dropping a request (if_req or d_req falling before its grant) is legal; no state change results.

Test Plan:
1. Reset with rst=1 mid-transfer (D_BUSY, mem_req=1) -> mem_req, d_rvalid and if_rvalid fall to 0 immediately; after release with no requests, outputs stay 0 and state is IDLE.
2. Fetch only: if_req=1, if_addr=32'h0000_0100; memory acks one cycle after mem_req with mem_rdata=32'h0000_0013 -> if_gnt at T; mem_addr=32'h100, mem_be=4'hF at T+1; if_rvalid=1 with if_rdata=32'h13 at T+2.
3. Contested access: if_req and d_req held high, d_we=1, d_addr=32'h2000, d_wdata=32'hDEAD_BEEF, d_be=4'h3; after each data ack, d_req is re-asserted with the same values. With STARVE_LIMIT=4 -> the first 4 contested arbitrations grant data, the 5th grants fetch, and the counter returns to 0.
4. Flush during IF_BUSY: fetch to 32'h40 granted; if_flush=1 two cycles before mem_ack -> no if_rvalid; next cycle if_req with if_addr=32'h80 is granted and returns its data normally.
5. Flush in IDLE with if_req=1 and d_req=1 (read 32'h3000) -> d_gnt=1, if_gnt=0 in that cycle; starve_cnt does not increment because the cycle is not contested.
6. Write completion: data write granted, mem_ack arrives 3 cycles later -> mem_req is held with stable mem_addr, mem_wdata and mem_be for all 3 cycles; d_rvalid pulses exactly once.
